pipe_stall_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RISC-V pipeline. Each cycle it decides the write-enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers, combining four sources:
- load-use hazards;
- taken branches resolved in EX;
- data-memory wait states;
- the shared iterative multiply/divide unit, which it sequences with a start/done handshake.

It also keeps a saturating-free stall-cycle counter for performance reporting.

---
 rtl/pipe_stall_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush scheduler for the 5-stage pipeline, sequencing
// the shared muldiv unit and counting PC-stall cycles.
module pipe_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_IFID,
    input  logic [4:0]       rs2_IFID,
    input  logic             useRs1_IFID,
    input  logic             useRs2_IFID,
    input  logic [4:0]       rd_IDEX,
    input  logic             memRead_IDEX,
    input  logic             mdValid_IDEX,
    input  logic             branchTaken_EX,
    input  logic             memReq_EXMEM,
    input  logic             dmemReady,
    input  logic             mdDone,
    output logic             PCEnable,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             ctlRst_IDEX,
    output logic             EXMEMWrite,
    output logic             EXMEMBubble,
    output logic             mdStart,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCycles
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MD_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use, mem_stall, md_wait;

    assign load_use = memRead_IDEX && rd_IDEX != 5'd0 &&
                      ((useRs1_IFID && rs1_IFID == rd_IDEX) || (useRs2_IFID && rs2_IFID == rd_IDEX));
    // MEM_WAIT keeps freezing until dmemReady, whatever memReq does meanwhile
    assign mem_stall = state_q != MD_BUSY && !dmemReady && (memReq_EXMEM || state_q == MEM_WAIT);
    assign md_wait   = state_q == MD_BUSY && !mdDone;

    always_comb begin
        state_d     = state_q;
        PCEnable    = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXWrite   = 1'b1;
        ctlRst_IDEX = 1'b0;
        EXMEMWrite  = 1'b1;
        EXMEMBubble = 1'b0;
        mdStart     = 1'b0;
        if (rst) begin
            state_d     = RUN;
            PCEnable    = 1'b0;
            IFIDWrite   = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXWrite   = 1'b0;
            ctlRst_IDEX = 1'b1;
            EXMEMWrite  = 1'b0;
            EXMEMBubble = 1'b1;
        end else if (md_wait) begin
            PCEnable    = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
        end else if (mem_stall) begin
            state_d    = MEM_WAIT;
            PCEnable   = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
        end else if (state_q != MD_BUSY && mdValid_IDEX) begin
            state_d     = MD_BUSY;
            mdStart     = 1'b1;
            PCEnable    = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
        end else begin
            // normal RUN, MEM_WAIT release, or muldiv completion
            state_d = RUN;
            if (branchTaken_EX) begin
                IFIDFlush   = 1'b1;
                ctlRst_IDEX = 1'b1;
            end else if (load_use) begin
                PCEnable    = 1'b0;
                IFIDWrite   = 1'b0;
                ctlRst_IDEX = 1'b1;
            end
        end
    end

    assign stall_d     = stall_q + CNT_W'(!PCEnable);
    assign mdBusy      = state_q == MD_BUSY;
    assign stallCycles = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: table-driven and sequenced checks of the stall scheduler,
// with a 4-bit counter instance for the wrap case.
module tb_pipe_stall_ctrl;
    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, mdv, br, mreq, drdy, mdd;
        logic [7:0] exp;
    } vec_t;

    // packed expected outputs: {PCEnable,IFIDWrite,IFIDFlush,IDEXWrite,ctlRst_IDEX,EXMEMWrite,EXMEMBubble,mdStart}
    localparam logic [7:0] DEF = 8'b1101_0100;
    localparam logic [7:0] LU  = 8'b0001_1100;
    localparam logic [7:0] BR  = 8'b1111_1100;
    localparam logic [7:0] FRZ = 8'b0000_0000;
    localparam logic [7:0] MDS = 8'b0000_0111;
    localparam logic [7:0] MDB = 8'b0000_0110;
    localparam logic [7:0] RST = 8'b0010_1010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_IFID = '0, rs2_IFID = '0, rd_IDEX = '0;
    logic        useRs1_IFID = 0, useRs2_IFID = 0, memRead_IDEX = 0, mdValid_IDEX = 0;
    logic        branchTaken_EX = 0, memReq_EXMEM = 0, dmemReady = 1, mdDone = 0;
    logic        PCEnable, IFIDWrite, IFIDFlush, IDEXWrite, ctlRst_IDEX, EXMEMWrite, EXMEMBubble, mdStart, mdBusy;
    logic [31:0] stallCycles;
    logic        pc4, ifw4, iff4, idw4, ctl4, exw4, exb4, st4, busy4;
    logic [3:0]  stall4;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned exp_cnt = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk(clk), .rst(rst), .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
        .useRs1_IFID(useRs1_IFID), .useRs2_IFID(useRs2_IFID), .rd_IDEX(rd_IDEX),
        .memRead_IDEX(memRead_IDEX), .mdValid_IDEX(mdValid_IDEX), .branchTaken_EX(branchTaken_EX),
        .memReq_EXMEM(memReq_EXMEM), .dmemReady(dmemReady), .mdDone(mdDone),
        .PCEnable(PCEnable), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXWrite(IDEXWrite),
        .ctlRst_IDEX(ctlRst_IDEX), .EXMEMWrite(EXMEMWrite), .EXMEMBubble(EXMEMBubble),
        .mdStart(mdStart), .mdBusy(mdBusy), .stallCycles(stallCycles)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
        .useRs1_IFID(useRs1_IFID), .useRs2_IFID(useRs2_IFID), .rd_IDEX(rd_IDEX),
        .memRead_IDEX(memRead_IDEX), .mdValid_IDEX(mdValid_IDEX), .branchTaken_EX(branchTaken_EX),
        .memReq_EXMEM(memReq_EXMEM), .dmemReady(dmemReady), .mdDone(mdDone),
        .PCEnable(pc4), .IFIDWrite(ifw4), .IFIDFlush(iff4), .IDEXWrite(idw4),
        .ctlRst_IDEX(ctl4), .EXMEMWrite(exw4), .EXMEMBubble(exb4),
        .mdStart(st4), .mdBusy(busy4), .stallCycles(stall4)
    );

    function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                                input logic a1, input logic a2, input logic [4:0] d, input logic m,
                                input logic v, input logic b, input logic q, input logic y,
                                input logic n, input logic [7:0] e);
        vec_t t;
        t.rst = r; t.rs1 = s1; t.rs2 = s2; t.u1 = a1; t.u2 = a2; t.rd = d; t.mr = m;
        t.mdv = v; t.br = b; t.mreq = q; t.drdy = y; t.mdd = n; t.exp = e;
        return t;
    endfunction

    // short form: lu=1 puts lw x5 in EX and add x6,x5,x1 in ID
    function automatic vec_t q(input logic r, input logic lu, input logic v, input logic b,
                               input logic mq, input logic y, input logic n, input logic [7:0] e);
        return mk(r, lu ? 5'd5 : 5'd1, 5'd1, lu, 1'b1, lu ? 5'd5 : 5'd0, lu, v, b, mq, y, n, e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic busy, input string nm);
        @(posedge clk);
        #1;
        rst = v.rst; rs1_IFID = v.rs1; rs2_IFID = v.rs2; useRs1_IFID = v.u1; useRs2_IFID = v.u2;
        rd_IDEX = v.rd; memRead_IDEX = v.mr; mdValid_IDEX = v.mdv; branchTaken_EX = v.br;
        memReq_EXMEM = v.mreq; dmemReady = v.drdy; mdDone = v.mdd;
        @(negedge clk);
        chk({nm, "_ctl"}, 32'({PCEnable, IFIDWrite, IFIDFlush, IDEXWrite, ctlRst_IDEX,
                               EXMEMWrite, EXMEMBubble, mdStart}), 32'(v.exp));
        chk({nm, "_busy"}, 32'(mdBusy), 32'(busy));
        chk({nm, "_cnt"}, stallCycles, exp_cnt);
        chk({nm, "_cnt4"}, 32'(stall4), 32'(exp_cnt[3:0]));
        if (v.rst) exp_cnt = 0;
        else if (!v.exp[7]) exp_cnt++;
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, DEF);
        tbl[1]  = mk(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0, 1, 0, LU);
        tbl[2]  = mk(0, 5'd2, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, 1, 0, LU);
        tbl[3]  = mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 1, 0, DEF);
        tbl[4]  = mk(0, 5'd5, 5'd3, 0, 1, 5'd5, 1, 0, 0, 0, 1, 0, DEF);
        tbl[5]  = mk(0, 5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0, 1, 0, DEF);
        tbl[6]  = mk(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 1, 0, 1, 0, BR);
        tbl[7]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0, BR);
        tbl[8]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, DEF);
        tbl[9]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1, DEF);
        tbl[10] = mk(0, 5'd9, 5'd4, 1, 0, 5'd4, 1, 0, 0, 0, 1, 0, DEF);

        apply(q(1, 0, 0, 0, 0, 1, 0, RST), 0, "reset0");
        apply(q(1, 1, 1, 1, 1, 0, 1, RST), 0, "reset1");
        apply(q(0, 0, 0, 0, 0, 1, 0, DEF), 0, "post_reset");

        for (int i = 0; i < 17; i++) apply(q(0, 1, 0, 0, 0, 1, 0, LU), 0, "wrap_lu");
        apply(q(0, 0, 0, 0, 0, 1, 0, DEF), 0, "wrap_after");

        for (int i = 0; i < 11; i++) apply(tbl[i], 0, $sformatf("tbl%0d", i));

        apply(q(0, 0, 1, 0, 0, 1, 0, MDS), 0, "md_start");
        apply(q(0, 0, 1, 0, 0, 1, 0, MDB), 1, "md_busy1");
        apply(q(0, 0, 1, 0, 1, 0, 0, MDB), 1, "md_busy2");
        apply(q(0, 0, 1, 0, 0, 1, 0, MDB), 1, "md_busy3");
        apply(q(0, 0, 1, 0, 0, 1, 1, DEF), 1, "md_done");
        apply(q(0, 0, 0, 0, 0, 1, 0, DEF), 0, "md_after");

        apply(q(0, 0, 1, 0, 1, 0, 0, FRZ), 0, "mw_frz1");
        apply(q(0, 0, 1, 0, 1, 0, 0, FRZ), 0, "mw_frz2");
        apply(q(0, 0, 1, 0, 1, 0, 0, FRZ), 0, "mw_frz3");
        apply(q(0, 0, 1, 0, 1, 1, 0, MDS), 0, "mw_start");
        apply(q(0, 0, 1, 0, 0, 1, 0, MDB), 1, "mw_busy");
        apply(q(0, 1, 1, 0, 0, 1, 1, LU), 1, "mw_done_lu");
        apply(q(0, 0, 0, 0, 0, 1, 0, DEF), 0, "mw_after");

        apply(q(0, 0, 0, 0, 1, 0, 0, FRZ), 0, "mb_frz1");
        apply(q(0, 1, 0, 0, 1, 0, 1, FRZ), 0, "mb_frz2");
        apply(q(0, 1, 0, 1, 1, 1, 0, BR), 0, "mb_rel_br");
        apply(q(0, 0, 0, 0, 0, 1, 0, DEF), 0, "mb_after");

        apply(q(0, 0, 1, 0, 0, 1, 0, MDS), 0, "db_start");
        apply(q(0, 1, 0, 1, 0, 1, 1, BR), 1, "db_done_br");
        apply(q(0, 0, 0, 0, 0, 1, 0, DEF), 0, "db_after");

        apply(q(0, 0, 1, 0, 0, 1, 0, MDS), 0, "rm_start");
        apply(q(0, 0, 1, 0, 0, 1, 0, MDB), 1, "rm_busy");
        apply(q(1, 0, 1, 0, 0, 1, 0, RST), 1, "rm_reset");
        apply(q(0, 0, 0, 0, 0, 1, 1, DEF), 0, "rm_late_done");
        apply(q(0, 0, 0, 0, 0, 1, 0, DEF), 0, "rm_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
